adc_frame_writer: RTL and testbench
===================================

# adc_frame_writer

Parametrised ADC frame writer. It snapshots NUM_CH samples on each rising edge of `adc_read_done` and packs them two per word. It then writes the frame as consecutive words into a circular window [BASE_ADDR..LAST_ADDR] of the dual-port RAM. It sits between the AD7606 front end and the dual-port RAM. Over the previous fixed 8-channel writer it adds a sample snapshot, a global enable, back-to-back write mode, overrun detection, a frame counter and a completion pulse.

## Interface
- NUM_CH, 8, channel count; even, ≥2
- SAMPLE_W, 16, bits per channel sample; RAM word = 2*SAMPLE_W
- ADDR_W, 14, RAM address width
- BASE_ADDR, 1, first data address (address 0 is reserved for control)
- LAST_ADDR, 14'h3F7, last data address; BASE_ADDR ≤ LAST_ADDR < 2^ADDR_W
- GAP, 1, 1 = one idle cycle between words; 0 = back-to-back writes

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  accepts new frames when high
- adc_read_done  in  1  level; rising edge = new sample set valid
- adc_data  in  NUM_CH*SAMPLE_W  flattened samples; ch0 in [SAMPLE_W-1:0]
- clear_overrun  in  1  clears the sticky overrun flag
- mem_wr_addr  out  ADDR_W  RAM write address
- mem_wr_data  out  2*SAMPLE_W  RAM write data
- mem_wr_en  out  1  RAM write strobe, one cycle per word
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last word of a frame
- overrun  out  1  sticky: a frame trigger was dropped
- frame_count  out  16  number of completed frames, wraps at 2^16

## Operation
- Edge detect: `prev` holds the registered `adc_read_done`. A trigger is `adc_read_done & ~prev`.
- States:
  - IDLE: trigger & enable → snapshot all of `adc_data` into a shadow register, set word index k=0, go to WRITE. Trigger & ~enable → ignored, no overrun.
  - WRITE: mem_wr_en=1, mem_wr_data = {ch[2k+1], ch[2k]} taken from the snapshot, mem_wr_addr = current address.
    - On leaving WRITE, the address advances: if addr ≥ LAST_ADDR then BASE_ADDR, else addr+1.
    - If k < NUM_CH/2−1: k++ and go to GAP_ST (GAP=1) or stay in WRITE (GAP=0).
    - If it was the last word: go to IDLE, pulse frame_done, increment frame_count.
  - GAP_ST: mem_wr_en=0, go to WRITE.
- The snapshot decouples output data from live `adc_data`. Changing the input mid-frame does not alter the words written.
- busy = (state ≠ IDLE).
- Overrun: a trigger while busy (including the final WRITE cycle) sets overrun and the trigger is dropped. If set and clear_overrun happen in the same cycle, set wins.
- Deasserting enable mid-frame does not abort; the frame completes.
- While idle, mem_wr_addr holds the next free address. Frames continue contiguously across the window wrap.

## Timing
- Reset values:
  - mem_wr_addr = BASE_ADDR
  - mem_wr_data = 0, mem_wr_en = 0
  - busy = 0, frame_done = 0, overrun = 0, frame_count = 0
  - prev = 0, state IDLE
- Trigger sampled at clock edge E0 → snapshot at E0; first mem_wr_en high in the cycle after E0.
- Word k is written in cycle k*(1+GAP)+1 after E0.
- Frame length W = NUM_CH/2 words. mem_wr_en is high for exactly W cycles.
- The last write is at cycle (W−1)*(1+GAP)+1. frame_done is high and busy low in the following cycle.
- All outputs are registered; there are no combinational paths from input to output.
- A held-high `adc_read_done` produces one trigger only. A new trigger is accepted from the first cycle in which busy is low.
- Reset mid-frame: all outputs return to reset values immediately; the partial frame is abandoned. Address restarts at BASE_ADDR.

## Test plan
- NUM_CH=8, GAP=1, idle at addr 1, ch_i = 16'h1000+i, one trigger → writes at addr 1,2,3,4 of 32'h1001_1000, 1003_1002, 1005_1004, 1007_1006. en pattern 1,0,1,0,1,0,1. Then frame_done=1, frame_count=1, mem_wr_addr=5.
- GAP=0, NUM_CH=4 → en high for 2 consecutive cycles at addr 1,2. frame_done in the next cycle.
- Wrap: start address 14'h3F6, NUM_CH=8 → writes at 3F6, 3F7, 1, 2; final mem_wr_addr=3.
- Overrun: second trigger 3 cycles after the first → overrun=1, only 4 writes occur, frame_count=1. A pulse on clear_overrun → overrun=0.
- Change adc_data after the trigger edge → written words still equal the snapshot values. Trigger with enable=0 → no writes and overrun stays 0.
- Assert rst_n low after the 2nd word → en=0, addr=1, frame_count=0. The next trigger writes normally from addr 1.

Source files
------------

// File: rtl/adc_frame_writer.sv
// Snapshots NUM_CH ADC samples on a rising adc_read_done and writes them, two per word,
// into a circular RAM window [BASE_ADDR..LAST_ADDR]. Adds overrun, frame counter and done pulse.
module adc_frame_writer #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 1,
    parameter int unsigned LAST_ADDR = 32'h3F7,
    parameter int unsigned GAP       = 1
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         adc_read_done,
    input  logic [NUM_CH*SAMPLE_W-1:0]   adc_data,
    input  logic                         clear_overrun,
    output logic [ADDR_W-1:0]            mem_wr_addr,
    output logic [2*SAMPLE_W-1:0]        mem_wr_data,
    output logic                         mem_wr_en,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun,
    output logic [15:0]                  frame_count
);

    localparam int unsigned WORD_W = 2 * SAMPLE_W;
    localparam int unsigned DATA_W = NUM_CH * SAMPLE_W;
    localparam int unsigned WORDS  = NUM_CH / 2;
    localparam int unsigned K_W    = $clog2(WORDS + 1);
    localparam int unsigned LAST_K = WORDS - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_prev;
    logic [DATA_W-1:0]   r_snap;
    logic [K_W-1:0]      r_k;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_data;
    logic                r_wr_en;
    logic                r_busy;
    logic                r_done;
    logic                r_ovr;
    logic [15:0]         r_count;

    logic                w_trig;
    logic                w_last;
    logic                w_snap_load;
    logic [K_W-1:0]      w_k_nxt;
    logic [K_W-1:0]      w_k_inc;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [WORD_W-1:0]   w_data_nxt;
    logic [WORD_W-1:0]   w_word_cur;
    logic [WORD_W-1:0]   w_word_inc;
    logic                w_wr_en_nxt;
    logic                w_done_nxt;
    logic                w_ovr_nxt;
    logic [15:0]         w_count_nxt;

    assign w_trig     = adc_read_done & ~r_prev;
    assign w_last     = (r_k == K_W'(LAST_K));
    assign w_k_inc    = r_k + K_W'(1);
    assign w_addr_inc = (r_addr >= ADDR_W'(LAST_ADDR)) ? ADDR_W'(BASE_ADDR)
                                                       : r_addr + ADDR_W'(1);

    // Snapshot word select for the current index and the one after it
    always_comb begin
        w_word_cur = '0;
        w_word_inc = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (r_k == K_W'(i))
                w_word_cur = r_snap[i*WORD_W +: WORD_W];
            if (w_k_inc == K_W'(i))
                w_word_inc = r_snap[i*WORD_W +: WORD_W];
        end
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_wr_en_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_count_nxt = r_count;
        w_snap_load = 1'b0;
        w_ovr_nxt   = r_ovr;

        if (clear_overrun)
            w_ovr_nxt = 1'b0;
        if (w_trig && (r_state != S_IDLE))
            w_ovr_nxt = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_trig && enable) begin
                    w_snap_load = 1'b1;
                    w_k_nxt     = '0;
                    w_state_nxt = S_WRITE;
                    w_wr_en_nxt = 1'b1;
                    w_data_nxt  = adc_data[WORD_W-1:0];
                end
            end
            S_WRITE: begin
                w_addr_nxt = w_addr_inc;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_count_nxt = r_count + 16'd1;
                end else begin
                    w_k_nxt = w_k_inc;
                    if (GAP != 0) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_WRITE;
                        w_wr_en_nxt = 1'b1;
                        w_data_nxt  = w_word_inc;
                    end
                end
            end
            S_GAP: begin
                w_state_nxt = S_WRITE;
                w_wr_en_nxt = 1'b1;
                w_data_nxt  = w_word_cur;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_prev  <= 1'b0;
            r_snap  <= '0;
            r_k     <= '0;
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_data  <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= adc_read_done;
            if (w_snap_load)
                r_snap <= adc_data;
            r_k     <= w_k_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_ovr   <= w_ovr_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign mem_wr_addr = r_addr;
    assign mem_wr_data = r_data;
    assign mem_wr_en   = r_wr_en;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign overrun     = r_ovr;
    assign frame_count = r_count;

endmodule

// File: tb/tb_adc_frame_writer.sv
// Directed bench for adc_frame_writer: default 8-ch/GAP=1, 4-ch back-to-back, and a small
// wrapping window instance, plus overrun, snapshot, enable and reset sequences.
module tb_adc_frame_writer;

    logic         sys_clk;
    logic         rst_n;
    logic         enable;
    logic         clear_overrun;
    logic [127:0] adc_data;
    logic         rd0, rd1, rd2;

    logic [13:0]  addr0, addr1, addr2;
    logic [31:0]  data0, data1, data2;
    logic         en0, en1, en2;
    logic         busy0, busy1, busy2;
    logic         done0, done1, done2;
    logic         ovr0, ovr1, ovr2;
    logic [15:0]  cnt0, cnt1, cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    adc_frame_writer dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .adc_read_done(rd0),
        .adc_data(adc_data), .clear_overrun(clear_overrun),
        .mem_wr_addr(addr0), .mem_wr_data(data0), .mem_wr_en(en0), .busy(busy0),
        .frame_done(done0), .overrun(ovr0), .frame_count(cnt0)
    );

    adc_frame_writer #(.NUM_CH(4), .GAP(0)) dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .adc_read_done(rd1),
        .adc_data(adc_data[63:0]), .clear_overrun(clear_overrun),
        .mem_wr_addr(addr1), .mem_wr_data(data1), .mem_wr_en(en1), .busy(busy1),
        .frame_done(done1), .overrun(ovr1), .frame_count(cnt1)
    );

    adc_frame_writer #(.BASE_ADDR(1), .LAST_ADDR(6)) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .adc_read_done(rd2),
        .adc_data(adc_data), .clear_overrun(clear_overrun),
        .mem_wr_addr(addr2), .mem_wr_data(data2), .mem_wr_en(en2), .busy(busy2),
        .frame_done(done2), .overrun(ovr2), .frame_count(cnt2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          sel;
        logic        rd;
        logic        en;
        logic [13:0] addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int sel, input logic rd, input logic en, input logic [13:0] addr,
                           input logic [31:0] data, input logic busy, input logic done,
                           input logic [15:0] cnt);
        vec_t v;
        v.sel = sel; v.rd = rd; v.en = en; v.addr = addr; v.data = data;
        v.busy = busy; v.done = done; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [127:0] a_data;
    logic [31:0]  a_word [4];
    logic [31:0]  wq[$];
    int           wr_cnt;

    initial begin
        for (int i = 0; i < 8; i++)
            a_data[i*16 +: 16] = 16'h1000 + 16'(i);
        for (int k = 0; k < 4; k++)
            a_word[k] = a_data[k*32 +: 32];

        // dut0: 8 ch, GAP=1, held-high trigger gives a single frame
        add_vec(0, 1, 1, 14'd1, 32'h1001_1000, 1, 0, 16'd0);
        add_vec(0, 1, 0, 14'd2, 32'h1001_1000, 1, 0, 16'd0);
        add_vec(0, 1, 1, 14'd2, 32'h1003_1002, 1, 0, 16'd0);
        add_vec(0, 1, 0, 14'd3, 32'h1003_1002, 1, 0, 16'd0);
        add_vec(0, 1, 1, 14'd3, 32'h1005_1004, 1, 0, 16'd0);
        add_vec(0, 0, 0, 14'd4, 32'h1005_1004, 1, 0, 16'd0);
        add_vec(0, 0, 1, 14'd4, 32'h1007_1006, 1, 0, 16'd0);
        add_vec(0, 0, 0, 14'd5, 32'h1007_1006, 0, 1, 16'd1);
        add_vec(0, 0, 0, 14'd5, 32'h1007_1006, 0, 0, 16'd1);
        // dut1: 4 ch, back-to-back
        add_vec(1, 1, 1, 14'd1, 32'h1001_1000, 1, 0, 16'd0);
        add_vec(1, 0, 1, 14'd2, 32'h1003_1002, 1, 0, 16'd0);
        add_vec(1, 0, 0, 14'd3, 32'h1003_1002, 0, 1, 16'd1);
        add_vec(1, 0, 0, 14'd3, 32'h1003_1002, 0, 0, 16'd1);
        // dut2: window 1..6, first frame then an immediate second frame that wraps
        add_vec(2, 1, 1, 14'd1, 32'h1001_1000, 1, 0, 16'd0);
        add_vec(2, 0, 0, 14'd2, 32'h1001_1000, 1, 0, 16'd0);
        add_vec(2, 0, 1, 14'd2, 32'h1003_1002, 1, 0, 16'd0);
        add_vec(2, 0, 0, 14'd3, 32'h1003_1002, 1, 0, 16'd0);
        add_vec(2, 0, 1, 14'd3, 32'h1005_1004, 1, 0, 16'd0);
        add_vec(2, 0, 0, 14'd4, 32'h1005_1004, 1, 0, 16'd0);
        add_vec(2, 0, 1, 14'd4, 32'h1007_1006, 1, 0, 16'd0);
        add_vec(2, 0, 0, 14'd5, 32'h1007_1006, 0, 1, 16'd1);
        add_vec(2, 1, 1, 14'd5, 32'h1001_1000, 1, 0, 16'd1);
        add_vec(2, 1, 0, 14'd6, 32'h1001_1000, 1, 0, 16'd1);
        add_vec(2, 1, 1, 14'd6, 32'h1003_1002, 1, 0, 16'd1);
        add_vec(2, 0, 0, 14'd1, 32'h1003_1002, 1, 0, 16'd1);
        add_vec(2, 0, 1, 14'd1, 32'h1005_1004, 1, 0, 16'd1);
        add_vec(2, 0, 0, 14'd2, 32'h1005_1004, 1, 0, 16'd1);
        add_vec(2, 0, 1, 14'd2, 32'h1007_1006, 1, 0, 16'd1);
        add_vec(2, 0, 0, 14'd3, 32'h1007_1006, 0, 1, 16'd2);
        add_vec(2, 0, 0, 14'd3, 32'h1007_1006, 0, 0, 16'd2);

        rst_n = 1'b0; enable = 1'b1; clear_overrun = 1'b0;
        rd0 = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
        adc_data = a_data;
        step(); step();
        chk("rst_addr", 32'(addr0), 32'd1);
        chk("rst_data", data0, 32'd0);
        chk("rst_en", 32'(en0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_ovr", 32'(ovr0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < vq.size(); i++) begin
            logic [13:0] a; logic [31:0] d; logic e, b, dn; logic [15:0] c;
            rd0 = (vq[i].sel == 0) ? vq[i].rd : 1'b0;
            rd1 = (vq[i].sel == 1) ? vq[i].rd : 1'b0;
            rd2 = (vq[i].sel == 2) ? vq[i].rd : 1'b0;
            step();
            case (vq[i].sel)
                0:       begin a = addr0; d = data0; e = en0; b = busy0; dn = done0; c = cnt0; end
                1:       begin a = addr1; d = data1; e = en1; b = busy1; dn = done1; c = cnt1; end
                default: begin a = addr2; d = data2; e = en2; b = busy2; dn = done2; c = cnt2; end
            endcase
            chk($sformatf("v%0d_en", i), 32'(e), 32'(vq[i].en));
            chk($sformatf("v%0d_addr", i), 32'(a), 32'(vq[i].addr));
            if (vq[i].en)
                chk($sformatf("v%0d_data", i), d, vq[i].data);
            chk($sformatf("v%0d_busy", i), 32'(b), 32'(vq[i].busy));
            chk($sformatf("v%0d_done", i), 32'(dn), 32'(vq[i].done));
            chk($sformatf("v%0d_cnt", i), 32'(c), 32'(vq[i].cnt));
        end
        rd2 = 1'b0;

        // Overrun: second trigger three cycles into a frame is dropped
        wr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            rd0 = (i == 0 || i == 3);
            step();
            if (en0) wr_cnt++;
        end
        chk("ovr_writes", 32'(wr_cnt), 32'd4);
        chk("ovr_set", 32'(ovr0), 32'd1);
        chk("ovr_cnt", 32'(cnt0), 32'd2);
        chk("ovr_addr", 32'(addr0), 32'd9);
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        chk("ovr_clear", 32'(ovr0), 32'd0);
        step();

        // Trigger on the final write cycle, with clear in the same cycle: set wins
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rd0 = (i == 0 || i == 7);
            clear_overrun = (i == 7);
            step();
            if (en0) wr_cnt++;
        end
        clear_overrun = 1'b0;
        chk("last_writes", 32'(wr_cnt), 32'd4);
        chk("last_ovr", 32'(ovr0), 32'd1);
        chk("last_cnt", 32'(cnt0), 32'd3);
        chk("last_addr", 32'(addr0), 32'd13);
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        chk("last_clear", 32'(ovr0), 32'd0);

        // Snapshot: live data and enable change after the trigger edge
        wq.delete();
        for (int i = 0; i < 10; i++) begin
            rd0 = (i == 0);
            step();
            if (i == 0) begin adc_data = ~a_data; enable = 1'b0; end
            if (en0) wq.push_back(data0);
        end
        chk("snap_nwords", 32'(wq.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < wq.size()) chk($sformatf("snap_w%0d", k), wq[k], a_word[k]);
        chk("snap_cnt", 32'(cnt0), 32'd4);
        chk("snap_addr", 32'(addr0), 32'd17);

        // Trigger with enable low is ignored
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rd0 = (i == 0);
            step();
            if (en0 || busy0) wr_cnt++;
        end
        chk("dis_writes", 32'(wr_cnt), 32'd0);
        chk("dis_ovr", 32'(ovr0), 32'd0);
        chk("dis_cnt", 32'(cnt0), 32'd4);
        adc_data = a_data; enable = 1'b1;

        // Reset after the second word abandons the frame
        rd0 = 1'b1; step();
        rd0 = 1'b0; step(); step();
        chk("mid_en", 32'(en0), 32'd1);
        chk("mid_addr", 32'(addr0), 32'd18);
        step();
        rst_n = 1'b0; #1;
        chk("mrst_en", 32'(en0), 32'd0);
        chk("mrst_addr", 32'(addr0), 32'd1);
        chk("mrst_cnt", 32'(cnt0), 32'd0);
        chk("mrst_busy", 32'(busy0), 32'd0);
        step(); rst_n = 1'b1; step();
        rd0 = 1'b1; step();
        chk("post_en", 32'(en0), 32'd1);
        chk("post_addr", 32'(addr0), 32'd1);
        chk("post_data", data0, 32'h1001_1000);
        rd0 = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("post_cnt", 32'(cnt0), 32'd1);
        chk("post_fin_addr", 32'(addr0), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
